// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic phase controller: ALL_RED -> GREEN -> YELLOW per phase, with a
// tick prescaler, per-phase pedestrian walk service and emergency preemption.
module traffic_phase_ctrl #(
  parameter int NUM_PHASES   = 4,
  parameter int TICK_DIV     = 10,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int PED_TICKS    = 5
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          enable,
  input  logic                          emergency,
  input  logic [NUM_PHASES-1:0]         ped_req,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         red,
  output logic [NUM_PHASES-1:0]         walk,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          tick
);

  localparam int PIW   = $clog2(NUM_PHASES);
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXD0 = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAXD  = (MAXD0 > ALLRED_TICKS) ? MAXD0 : ALLRED_TICKS;
  localparam int TW    = $clog2(MAXD + 1);
  localparam logic [NUM_PHASES-1:0] ONE = {{(NUM_PHASES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW} state_e;

  state_e                  state_q, state_d;
  logic [PIW-1:0]          phase_q, phase_d;
  logic                    first_q, first_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [NUM_PHASES-1:0]   ped_pend_q, ped_pend_d;
  logic [NUM_PHASES-1:0]   walk_q, walk_d;
  logic [NUM_PHASES-1:0]   green_q, green_d;
  logic [NUM_PHASES-1:0]   yellow_q, yellow_d;
  logic [NUM_PHASES-1:0]   red_q, red_d;
  logic                    tick_q, tick_d;

  logic                    tick_evt;
  logic                    last_tick;
  logic [TW-1:0]           dur;
  logic [NUM_PHASES-1:0]   sel_d;
  logic [NUM_PHASES-1:0]   ped_any;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    first_d   = first_q;
    presc_d   = presc_q;
    tcnt_d    = tcnt_q;
    walk_d    = walk_q;
    ped_any   = ped_pend_q | ped_req;
    ped_pend_d = ped_any;

    case (state_q)
      S_GREEN:  dur = TW'(GREEN_TICKS);
      S_YELLOW: dur = TW'(YELLOW_TICKS);
      default:  dur = TW'(ALLRED_TICKS);
    endcase
    tick_evt  = enable && (presc_q == PW'(TICK_DIV - 1));
    last_tick = tick_evt && (tcnt_q == dur - TW'(1));

    if (enable) begin
      presc_d = tick_evt ? '0 : presc_q + PW'(1);
      if (tick_evt) tcnt_d = tcnt_q + TW'(1);
    end

    case (state_q)
      S_ALL_RED: begin
        // Emergency pins ALL_RED at the start of its interval until released.
        if (emergency) begin
          presc_d = '0;
          tcnt_d  = '0;
        end else if (last_tick) begin
          state_d = S_GREEN;
          if (first_q) first_d = 1'b0;
          else         phase_d = (phase_q == PIW'(NUM_PHASES - 1)) ? '0 : phase_q + PIW'(1);
        end
      end
      S_GREEN: begin
        if (emergency || last_tick) state_d = S_YELLOW;
        else if (tick_evt && (tcnt_q == TW'(PED_TICKS - 1))) walk_d = '0;
      end
      S_YELLOW: begin
        if (last_tick) state_d = S_ALL_RED;
      end
      default: state_d = S_ALL_RED;
    endcase

    sel_d = ONE << phase_d;
    // Every state change restarts timing; green entry serves and clears the walk request.
    if (state_d != state_q) begin
      presc_d = '0;
      tcnt_d  = '0;
      walk_d  = '0;
      if (state_d == S_GREEN) begin
        walk_d     = ped_any & sel_d;
        ped_pend_d = ped_any & ~sel_d;
      end
    end

    green_d  = (state_d == S_GREEN)  ? sel_d : '0;
    yellow_d = (state_d == S_YELLOW) ? sel_d : '0;
    red_d    = ~(green_d | yellow_d);
    tick_d   = (presc_d == PW'(TICK_DIV - 1));
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_ALL_RED;
      phase_q    <= '0;
      first_q    <= 1'b1;
      presc_q    <= '0;
      tcnt_q     <= '0;
      ped_pend_q <= '0;
      walk_q     <= '0;
      green_q    <= '0;
      yellow_q   <= '0;
      red_q      <= '1;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      first_q    <= first_d;
      presc_q    <= presc_d;
      tcnt_q     <= tcnt_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
      green_q    <= green_d;
      yellow_q   <= yellow_d;
      red_q      <= red_d;
      tick_q     <= tick_d;
    end
  end

  assign green     = green_q;
  assign yellow    = yellow_q;
  assign red       = red_q;
  assign walk      = walk_q;
  assign phase_idx = phase_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl at default parameters: lamp sequence, walk
// service, emergency preemption, enable freeze and asynchronous reset.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rstb;
  logic       enable;
  logic       emergency;
  logic [3:0] ped_req;
  logic [3:0] green, yellow, red, walk;
  logic [1:0] phase_idx;
  logic       tick;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk       (clk),
    .rstb      (rstb),
    .enable    (enable),
    .emergency (emergency),
    .ped_req   (ped_req),
    .green     (green),
    .yellow    (yellow),
    .red       (red),
    .walk      (walk),
    .phase_idx (phase_idx),
    .tick      (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // n consecutive samples with fixed phase/lamps/walk; red is implied by green/yellow.
  task automatic seg(input string tag, input int n, input logic [1:0] p,
                     input logic [3:0] g, input logic [3:0] y, input logic [3:0] w);
    logic [3:0] r;
    logic       onehot;
    r = ~(g | y);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d]", tag, i), {14'd0, phase_idx, green, yellow, red, walk},
          {14'd0, p, g, y, r, w});
      onehot = ((green | yellow | red) == 4'hF) &&
               (((green & yellow) | (green & red) | (yellow & red)) == 4'h0);
      chk($sformatf("%s_1hot[%0d]", tag, i), {31'd0, onehot}, 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_lamps"}, {15'd0, green, yellow, red, walk, tick}, {15'd0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0});
    chk({tag, "_phase"}, {30'd0, phase_idx}, 32'd0);
  endtask

  initial begin
    rstb      = 1'b0;
    enable    = 1'b1;
    emergency = 1'b0;
    ped_req   = 4'h0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rstb = 1'b1;

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tick[%0d]", i), {31'd0, tick}, {31'd0, (i == 9)});
      @(posedge clk);
      @(negedge clk);
    end
    seg("ar_init", 10, 2'd0, 4'h0, 4'h0, 4'h0);

    // Phase 0 green with a one-cycle pedestrian pulse for phase 2
    seg("g0a", 5, 2'd0, 4'h1, 4'h0, 4'h0);
    ped_req = 4'b0100;
    seg("g0b", 1, 2'd0, 4'h1, 4'h0, 4'h0);
    ped_req = 4'h0;
    seg("g0c", 74, 2'd0, 4'h1, 4'h0, 4'h0);
    seg("y0", 30, 2'd0, 4'h0, 4'h1, 4'h0);
    seg("ar0", 20, 2'd0, 4'h0, 4'h0, 4'h0);

    seg("g1", 80, 2'd1, 4'h2, 4'h0, 4'h0);
    seg("y1", 30, 2'd1, 4'h0, 4'h2, 4'h0);
    seg("ar1", 20, 2'd1, 4'h0, 4'h0, 4'h0);

    seg("g2walk", 50, 2'd2, 4'h4, 4'h0, 4'h4);
    seg("g2", 30, 2'd2, 4'h4, 4'h0, 4'h0);
    seg("y2", 30, 2'd2, 4'h0, 4'h4, 4'h0);
    seg("ar2", 20, 2'd2, 4'h0, 4'h0, 4'h0);

    seg("g3", 80, 2'd3, 4'h8, 4'h0, 4'h0);
    seg("y3", 30, 2'd3, 4'h0, 4'h8, 4'h0);
    seg("ar3", 20, 2'd3, 4'h0, 4'h0, 4'h0);

    seg("g0_wrap", 80, 2'd0, 4'h1, 4'h0, 4'h0);
    seg("y0_wrap", 30, 2'd0, 4'h0, 4'h1, 4'h0);
    seg("ar0_wrap", 20, 2'd0, 4'h0, 4'h0, 4'h0);

    // Emergency 15 cycles into phase 1 green, held for 100 cycles
    seg("g1_pre", 15, 2'd1, 4'h2, 4'h0, 4'h0);
    emergency = 1'b1;
    seg("em_g", 1, 2'd1, 4'h2, 4'h0, 4'h0);
    seg("em_y", 30, 2'd1, 4'h0, 4'h2, 4'h0);
    seg("em_ar", 69, 2'd1, 4'h0, 4'h0, 4'h0);
    emergency = 1'b0;
    seg("rel_ar", 20, 2'd1, 4'h0, 4'h0, 4'h0);
    seg("g2_nowalk", 80, 2'd2, 4'h4, 4'h0, 4'h0);

    // Enable dropped for 37 cycles mid-yellow
    seg("y2_pre", 12, 2'd2, 4'h0, 4'h4, 4'h0);
    enable = 1'b0;
    seg("y2_frozen", 37, 2'd2, 4'h0, 4'h4, 4'h0);
    enable = 1'b1;
    seg("y2_post", 18, 2'd2, 4'h0, 4'h4, 4'h0);
    seg("ar2b", 20, 2'd2, 4'h0, 4'h0, 4'h0);
    seg("g3b", 20, 2'd3, 4'h8, 4'h0, 4'h0);

    // Asynchronous reset between clock edges, mid-green
    #2 rstb = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    chk_reset("rst_hold");
    rstb = 1'b1;
    seg("r_ar", 20, 2'd0, 4'h0, 4'h0, 4'h0);
    seg("r_g0", 80, 2'd0, 4'h1, 4'h0, 4'h0);
    seg("r_y0", 30, 2'd0, 4'h0, 4'h1, 4'h0);
    seg("r_ar0", 20, 2'd0, 4'h0, 4'h0, 4'h0);
    seg("r_g1", 5, 2'd1, 4'h2, 4'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
